ball_step_ctrl: RTL and testbench
=================================

# ball_step_ctrl

Sequencing controller for the `ball_control` combinational datapath. It holds the registered game state: brick map, ball position, ball speed and ball direction. It presents that state to the datapath and commits the datapath's `next_*` results once per frame step. Around the datapath it runs the game flow: serve, launch, pause, life loss, game over and level clear. It sits between the frame-tick divider / input debouncers and the VGA renderer and sound block.

## Interface

Parameters:
- `INIT_BRICKS`, 1440'h0: brick map loaded at reset and on restart; 480 cells × 3 bits, 20 cols × 24 rows.
- `VX0`, 10'd4: initial horizontal speed.
- `VY0`, 10'd4: initial vertical speed.
- `VY_MAX`, 10'd9: vertical speed ceiling.
- `LIVES0`, 2'd3: lives at game start.
- `LOST_STEPS`, 6'd60: step ticks held in LOST.

Ports (name, direction, width, meaning):
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous, active-low.
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `step_tick`  in  1  one-cycle pulse, one per game frame
- `start`  in  1  one-cycle pulse, (re)start game
- `launch`  in  1  one-cycle pulse, release ball from paddle
- `pause`  in  1  one-cycle pulse, toggle pause
- `board_x`  in  10  paddle left edge
- `nxt_bricks`, `nxt_ball_x`, `nxt_ball_y`, `nxt_ball_vx`, `nxt_ball_vy`, `nxt_ball_dir`, `nxt_coll`  in  1440/10/10/10/10/2/1  datapath results
- `bricks`, `ball_x`, `ball_y`, `ball_vx`, `ball_vy`, `ball_dir`  out  1440/10/10/10/10/2  registered state, to datapath and renderer
- `lives`  out  2  remaining lives
- `score`  out  16  bricks-hit steps, saturating at 16'hFFFF
- `state`  out  3  FSM state code
- `sfx_pulse`  out  1  one-cycle collision sound strobe

## Operation

States and codes: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, OVER=5, WIN=6.

Transitions:
- IDLE/OVER/WIN + `start`: reinitialise bricks, lives, score, speeds and hit counter, then go to SERVE. `start` is ignored in every other state.
- SERVE + `launch`: go to PLAY; `ball_dir`←2'b10 (up-right).
- PLAY + `pause`: go to PAUSE. PAUSE + `pause`: go to PLAY.
- PLAY + `step_tick`, miss check first:
  - Miss condition: `ball_dir[0]`=1 and `ball_y`+10+`ball_vy` > 530, computed in 11 bits.
  - On a miss: x/y/dir are not committed; `lives` decrements.
  - If `lives` was 1: go to OVER (lives=0).
  - Otherwise: go to LOST and clear the step counter.
- PLAY + `step_tick`, no miss:
  - Commit all `nxt_*` state.
  - If `nxt_bricks`≠`bricks`: `score`+1, and the 3-bit hit counter +1.
  - On hit-counter wrap 7→0: `ball_vy`←min(`ball_vy`+1, `VY_MAX`).
  - If `nxt_bricks`==0: go to WIN.
- LOST: count `step_tick`s; at count `LOST_STEPS`, go to SERVE.

Ball tracking:
- In IDLE, SERVE and LOST, every cycle: `ball_x`←`board_x`+40 (10-bit wrap), `ball_y`←455.
- In PAUSE, OVER and WIN all state is frozen.

Simultaneous events:
- `pause` and `step_tick` in PLAY: the pause wins and there is no commit.
- `launch` and `step_tick` in SERVE: the launch wins and there is no commit.
- `start` and `launch` in IDLE: go to SERVE only.

Sound strobe: `sfx_pulse`=1 the cycle after a PLAY commit with `nxt_coll`=1.

## Timing

- Reset values: state=IDLE, `bricks`=`INIT_BRICKS`, `ball_x`=0, `ball_y`=455, `ball_vx`=`VX0`, `ball_vy`=`VY0`, `ball_dir`=2'b10, `lives`=`LIVES0`, `score`=0, `sfx_pulse`=0, hit and step counters 0.
- All outputs are registered.
- Commit latency: outputs reflect `nxt_*` one clock after the `step_tick` edge.
- The state change is visible one clock after the triggering pulse.
- The datapath is combinational: `nxt_*` are sampled in the same cycle as `step_tick`.
- Reset asserted mid-step discards the commit; all registers go to their reset values immediately.
- Inputs are assumed synchronous single-cycle pulses; a held level re-triggers every cycle.

## Structure

- Package `breakout_pkg`:
  - state enum and codes;
  - geometry constants: BALL_W=16, BALL_H=10, BOARD_Y=467, SERVE_Y=455, SERVE_DX=40, MISS_Y=530;
  - brick-map widths: 1440 bits, 3-bit cell.
- One sub-module, `step_counter`: a 6-bit tick counter with clear and terminal flag, used for the LOST hold.
- Score saturation and speed-up logic stay inline.

## Test plan

1. Reset, then `start`, with `board_x`=100 → state SERVE, `ball_x`=140, `ball_y`=455, `lives`=3, `score`=0.
2. `launch`, then `step_tick`, with stub `nxt_ball_x`=144, `nxt_ball_y`=451, `nxt_coll`=1 → `ball_x`=144, `ball_y`=451 the next cycle; `sfx_pulse` high for exactly one cycle.
3. Eight PLAY steps, each with `nxt_bricks` differing from `bricks` → `score`=8, `ball_vy`=5. Repeat from `ball_vy`=9 → stays 9.
4. `ball_y`=520, dir=2'b11, `ball_vy`=4, `step_tick` → miss, `lives`=2, state LOST. After 60 `step_tick`s → SERVE. Repeat the miss until `lives`=0 → OVER; further ticks change nothing.
5. `nxt_bricks`=0 on a commit → WIN; `start` → SERVE with `bricks`=`INIT_BRICKS`.
6. `pause` and `step_tick` in the same cycle → PAUSE, no state change. Then `rst_n` low mid-PLAY → IDLE and all reset values asynchronously.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared game-flow types and geometry for the breakout controller and its helpers.
// State codes are fixed because the renderer and sound block decode them directly.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LOST  = 3'd4,
    ST_OVER  = 3'd5,
    ST_WIN   = 3'd6
  } state_e;

  localparam logic [9:0]  BALL_W   = 10'd16;
  localparam logic [9:0]  BALL_H   = 10'd10;
  localparam logic [9:0]  BOARD_Y  = 10'd467;
  localparam logic [9:0]  SERVE_Y  = 10'd455;
  localparam logic [9:0]  SERVE_DX = 10'd40;
  localparam logic [10:0] MISS_Y   = 11'd530;

  localparam int BRICK_BITS = 1440;
  localparam int CELL_W     = 3;

endpackage

// File: rtl/step_counter.sv
// Counts enabled ticks from a clear; last_o flags that the next enabled tick
// is the limit-th one, so the owner can act on that same tick.
module step_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [5:0] limit_i,
  output logic       last_o
);

  logic [5:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == (limit_i - 6'd1));

endmodule

// File: rtl/ball_step_ctrl.sv
// Game-flow sequencer around the combinational ball_control datapath: holds the
// registered game state and commits the datapath's results once per frame step.
module ball_step_ctrl
  import breakout_pkg::*;
#(
  parameter logic [BRICK_BITS-1:0] INIT_BRICKS = '0,
  parameter logic [9:0]            VX0         = 10'd4,
  parameter logic [9:0]            VY0         = 10'd4,
  parameter logic [9:0]            VY_MAX      = 10'd9,
  parameter logic [1:0]            LIVES0      = 2'd3,
  parameter logic [5:0]            LOST_STEPS  = 6'd60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_tick,
  input  logic                  start,
  input  logic                  launch,
  input  logic                  pause,
  input  logic [9:0]            board_x,
  input  logic [BRICK_BITS-1:0] nxt_bricks,
  input  logic [9:0]            nxt_ball_x,
  input  logic [9:0]            nxt_ball_y,
  input  logic [9:0]            nxt_ball_vx,
  input  logic [9:0]            nxt_ball_vy,
  input  logic [1:0]            nxt_ball_dir,
  input  logic                  nxt_coll,
  output logic [BRICK_BITS-1:0] bricks,
  output logic [9:0]            ball_x,
  output logic [9:0]            ball_y,
  output logic [9:0]            ball_vx,
  output logic [9:0]            ball_vy,
  output logic [1:0]            ball_dir,
  output logic [1:0]            lives,
  output logic [15:0]           score,
  output logic [2:0]            state,
  output logic                  sfx_pulse
);

  state_e                state_q, state_d;
  logic [BRICK_BITS-1:0] bricks_q, bricks_d;
  logic [9:0]            ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]            ball_vx_q, ball_vx_d, ball_vy_q, ball_vy_d;
  logic [1:0]            ball_dir_q, ball_dir_d;
  logic [1:0]            lives_q, lives_d;
  logic [15:0]           score_q, score_d;
  logic [2:0]            hits_q, hits_d;
  logic                  sfx_q, sfx_d;
  logic                  track, cnt_clear, cnt_en, lost_last, miss;
  logic [10:0]           miss_sum;

  step_counter u_lost_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .limit_i (LOST_STEPS),
    .last_o  (lost_last)
  );

  // A falling ball is lost once its bottom edge would pass below the paddle zone.
  assign miss_sum = {1'b0, ball_y_q} + {1'b0, BALL_H} + {1'b0, ball_vy_q};
  assign miss     = ball_dir_q[0] && (miss_sum > MISS_Y);

  always_comb begin
    state_d    = state_q;
    bricks_d   = bricks_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    ball_vx_d  = ball_vx_q;
    ball_vy_d  = ball_vy_q;
    ball_dir_d = ball_dir_q;
    lives_d    = lives_q;
    score_d    = score_q;
    hits_d     = hits_q;
    sfx_d      = 1'b0;
    track      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER, ST_WIN: begin
        track = (state_q == ST_IDLE);
        if (start) begin
          bricks_d  = INIT_BRICKS;
          lives_d   = LIVES0;
          score_d   = '0;
          ball_vx_d = VX0;
          ball_vy_d = VY0;
          hits_d    = '0;
          state_d   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        track = 1'b1;
        if (launch) begin
          state_d    = ST_PLAY;
          ball_dir_d = 2'b10;
        end
      end
      ST_PLAY: begin
        if (pause) begin
          state_d = ST_PAUSE;
        end else if (step_tick) begin
          if (miss) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = ST_OVER;
            end else begin
              state_d   = ST_LOST;
              cnt_clear = 1'b1;
            end
          end else begin
            bricks_d   = nxt_bricks;
            ball_x_d   = nxt_ball_x;
            ball_y_d   = nxt_ball_y;
            ball_vx_d  = nxt_ball_vx;
            ball_vy_d  = nxt_ball_vy;
            ball_dir_d = nxt_ball_dir;
            sfx_d      = nxt_coll;
            // Every eighth brick-hitting step speeds the ball up, capped at VY_MAX.
            if (nxt_bricks != bricks_q) begin
              score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
              hits_d  = hits_q + 3'd1;
              if (hits_q == 3'd7) begin
                ball_vy_d = (nxt_ball_vy >= VY_MAX) ? VY_MAX : nxt_ball_vy + 10'd1;
              end
            end
            if (nxt_bricks == '0) begin
              state_d = ST_WIN;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (pause) begin
          state_d = ST_PLAY;
        end
      end
      ST_LOST: begin
        track = 1'b1;
        if (step_tick) begin
          cnt_en = 1'b1;
          if (lost_last) begin
            state_d = ST_SERVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (track) begin
      ball_x_d = board_x + SERVE_DX;
      ball_y_d = SERVE_Y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bricks_q   <= INIT_BRICKS;
      ball_x_q   <= '0;
      ball_y_q   <= SERVE_Y;
      ball_vx_q  <= VX0;
      ball_vy_q  <= VY0;
      ball_dir_q <= 2'b10;
      lives_q    <= LIVES0;
      score_q    <= '0;
      hits_q     <= '0;
      sfx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bricks_q   <= bricks_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      ball_vx_q  <= ball_vx_d;
      ball_vy_q  <= ball_vy_d;
      ball_dir_q <= ball_dir_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      hits_q     <= hits_d;
      sfx_q      <= sfx_d;
    end
  end

  assign state     = state_q;
  assign bricks    = bricks_q;
  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign ball_vx   = ball_vx_q;
  assign ball_vy   = ball_vy_q;
  assign ball_dir  = ball_dir_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign sfx_pulse = sfx_q;

endmodule

// File: tb/tb_ball_step_ctrl.sv
// Self-checking bench for ball_step_ctrl: directed game-flow scenarios plus a
// randomized run against a game-level reference model.
module tb_ball_step_ctrl;

  localparam logic [1439:0] INIT = 1440'hABCD_EF01_2345_6789;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_tick = 1'b0, start = 1'b0, launch = 1'b0, pause = 1'b0;
  logic [9:0]    board_x = '0;
  logic [1439:0] nxt_bricks = '0;
  logic [9:0]    nxt_ball_x = '0, nxt_ball_y = '0, nxt_ball_vx = '0, nxt_ball_vy = '0;
  logic [1:0]    nxt_ball_dir = '0;
  logic          nxt_coll = 1'b0;
  logic [1439:0] bricks;
  logic [9:0]    ball_x, ball_y, ball_vx, ball_vy;
  logic [1:0]    ball_dir, lives;
  logic [15:0]   score;
  logic [2:0]    state;
  logic          sfx_pulse;

  int compared = 0;
  int mismatched = 0;

  // Reference game model, kept as plain integers
  int            mState, mX, mY, mVx, mVy, mDir, mLives, mScore, mHits, mLost, mSfx;
  logic [1439:0] mBricks;

  always #5 clk = ~clk;

  ball_step_ctrl #(.INIT_BRICKS(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .start(start), .launch(launch),
    .pause(pause), .board_x(board_x), .nxt_bricks(nxt_bricks), .nxt_ball_x(nxt_ball_x),
    .nxt_ball_y(nxt_ball_y), .nxt_ball_vx(nxt_ball_vx), .nxt_ball_vy(nxt_ball_vy),
    .nxt_ball_dir(nxt_ball_dir), .nxt_coll(nxt_coll), .bricks(bricks), .ball_x(ball_x),
    .ball_y(ball_y), .ball_vx(ball_vx), .ball_vy(ball_vy), .ball_dir(ball_dir),
    .lives(lives), .score(score), .state(state), .sfx_pulse(sfx_pulse)
  );

  task automatic modelReset();
    mState = 0; mBricks = INIT; mX = 0; mY = 455; mVx = 4; mVy = 4; mDir = 2;
    mLives = 3; mScore = 0; mHits = 0; mLost = 0; mSfx = 0;
  endtask

  // Applies the game rules to the inputs currently driven.
  task automatic modelCycle();
    int prev;
    int nextSfx;
    bit hit;
    prev = mState;
    nextSfx = 0;
    case (mState)
      0, 5, 6: if (start) begin
        mBricks = INIT; mLives = 3; mScore = 0; mVx = 4; mVy = 4; mHits = 0; mState = 1;
      end
      1: if (launch) begin mState = 2; mDir = 2; end
      2: if (pause) mState = 3;
         else if (step_tick) begin
           if ((mDir % 2) == 1 && ((mY + 10 + mVy) % 2048) > 530) begin
             mLives = mLives - 1;
             if (mLives == 0) mState = 5;
             else begin mState = 4; mLost = 0; end
           end else begin
             hit = (nxt_bricks != mBricks);
             mBricks = nxt_bricks; mX = int'(nxt_ball_x); mY = int'(nxt_ball_y);
             mVx = int'(nxt_ball_vx); mVy = int'(nxt_ball_vy); mDir = int'(nxt_ball_dir);
             if (hit) begin
               mScore = (mScore < 65535) ? mScore + 1 : 65535;
               mHits = mHits + 1;
               if (mHits % 8 == 0) mVy = (mVy + 1 > 9) ? 9 : mVy + 1;
             end
             nextSfx = int'(nxt_coll);
             if (nxt_bricks == '0) mState = 6;
           end
         end
      3: if (pause) mState = 2;
      4: if (step_tick) begin
           mLost = mLost + 1;
           if (mLost == 60) mState = 1;
         end
      default: ;
    endcase
    if (prev == 0 || prev == 1 || prev == 4) begin
      mX = (int'(board_x) + 40) % 1024;
      mY = 455;
    end
    mSfx = nextSfx;
  endtask

  task automatic cycle();
    modelCycle();
    @(posedge clk);
    #1;
    start = 1'b0; launch = 1'b0; pause = 1'b0; step_tick = 1'b0;
  endtask

  // Datapath stub that proposes "nothing changes" for the next step.
  task automatic holdNxt();
    nxt_bricks = mBricks; nxt_ball_x = 10'(mX); nxt_ball_y = 10'(mY);
    nxt_ball_vx = 10'(mVx); nxt_ball_vy = 10'(mVy); nxt_ball_dir = 2'(mDir); nxt_coll = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compared++; if (state !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", state); end
    compared++; if (bricks !== INIT) begin mismatched++; $display("FAIL reset_bricks: got %h expected %h", bricks[63:0], INIT[63:0]); end
    compared++; if (ball_x !== 10'd0 || ball_y !== 10'd455) begin mismatched++; $display("FAIL reset_pos: got %0d,%0d expected 0,455", ball_x, ball_y); end
    compared++; if (ball_vx !== 10'd4 || ball_vy !== 10'd4 || ball_dir !== 2'b10) begin mismatched++; $display("FAIL reset_motion: got %0d,%0d,%0d expected 4,4,2", ball_vx, ball_vy, ball_dir); end
    compared++; if (lives !== 2'd3 || score !== 16'd0 || sfx_pulse !== 1'b0) begin mismatched++; $display("FAIL reset_counts: got %0d,%0d,%0d expected 3,0,0", lives, score, sfx_pulse); end
    rst_n = 1'b1;
  endtask

  task automatic test_serve();
    board_x = 10'd100;
    start = 1'b1;
    cycle();
    compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL serve_state: got %0d expected 1", state); end
    compared++; if (ball_x !== 10'd140 || ball_y !== 10'd455) begin mismatched++; $display("FAIL serve_pos: got %0d,%0d expected 140,455", ball_x, ball_y); end
    compared++; if (lives !== 2'd3 || score !== 16'd0) begin mismatched++; $display("FAIL serve_counts: got %0d,%0d expected 3,0", lives, score); end
  endtask

  task automatic test_launch_commit();
    launch = 1'b1;
    cycle();
    compared++; if (state !== 3'd2 || ball_dir !== 2'b10) begin mismatched++; $display("FAIL launch: got state %0d dir %0d expected 2,2", state, ball_dir); end
    holdNxt();
    nxt_ball_x = 10'd144; nxt_ball_y = 10'd451; nxt_coll = 1'b1;
    step_tick = 1'b1;
    cycle();
    compared++; if (ball_x !== 10'd144 || ball_y !== 10'd451) begin mismatched++; $display("FAIL commit_pos: got %0d,%0d expected 144,451", ball_x, ball_y); end
    compared++; if (sfx_pulse !== 1'b1) begin mismatched++; $display("FAIL sfx_high: got %0d expected 1", sfx_pulse); end
    nxt_coll = 1'b0;
    cycle();
    compared++; if (sfx_pulse !== 1'b0) begin mismatched++; $display("FAIL sfx_one_cycle: got %0d expected 0", sfx_pulse); end
  endtask

  task automatic hitSteps(input int n);
    logic [1439:0] one;
    one = 1440'd1;
    for (int i = 0; i < n; i++) begin
      holdNxt();
      nxt_bricks = mBricks ^ (one << (3 * i));
      nxt_ball_y = 10'd200; nxt_ball_dir = 2'b10;
      step_tick = 1'b1;
      cycle();
    end
  endtask

  task automatic test_speedup();
    hitSteps(8);
    compared++; if (score !== 16'd8) begin mismatched++; $display("FAIL speedup_score: got %0d expected 8", score); end
    compared++; if (ball_vy !== 10'd5) begin mismatched++; $display("FAIL speedup_vy: got %0d expected 5", ball_vy); end
  endtask

  task automatic test_vy_ceiling();
    holdNxt();
    nxt_ball_vy = 10'd9;
    step_tick = 1'b1;
    cycle();
    hitSteps(8);
    compared++; if (ball_vy !== 10'd9) begin mismatched++; $display("FAIL vy_ceiling: got %0d expected 9", ball_vy); end
    compared++; if (score !== 16'd16) begin mismatched++; $display("FAIL ceiling_score: got %0d expected 16", score); end
  endtask

  // Puts the ball at y=520 falling with vy=4 (first passing the y=516 no-miss boundary).
  task automatic setupFall();
    holdNxt(); nxt_ball_y = 10'd516; nxt_ball_dir = 2'b11; nxt_ball_vy = 10'd4;
    step_tick = 1'b1; cycle();
    holdNxt(); nxt_ball_y = 10'd520;
    step_tick = 1'b1; cycle();
  endtask

  task automatic test_miss_lost();
    setupFall();
    compared++; if (state !== 3'd2 || ball_y !== 10'd520) begin mismatched++; $display("FAIL miss_boundary: got state %0d y %0d expected 2,520", state, ball_y); end
    for (int rem = 3; rem >= 1; rem--) begin
      if (rem != 3) begin
        launch = 1'b1; cycle();
        setupFall();
      end
      holdNxt(); nxt_ball_y = 10'd300;
      step_tick = 1'b1; cycle();
      compared++; if (lives !== 2'(rem - 1) || ball_y !== 10'd520) begin mismatched++; $display("FAIL miss_lives: got %0d y %0d expected %0d,520", lives, ball_y, rem - 1); end
      compared++; if (state !== ((rem == 1) ? 3'd5 : 3'd4)) begin mismatched++; $display("FAIL miss_state: got %0d expected %0d", state, (rem == 1) ? 5 : 4); end
      if (rem != 1) begin
        for (int t = 1; t <= 60; t++) begin
          step_tick = 1'b1; cycle();
          if (t == 59) begin
            compared++; if (state !== 3'd4) begin mismatched++; $display("FAIL lost_hold: got %0d expected 4", state); end
          end
        end
        compared++; if (state !== 3'd1 || ball_y !== 10'd455) begin mismatched++; $display("FAIL lost_to_serve: got state %0d y %0d expected 1,455", state, ball_y); end
      end
    end
  endtask

  task automatic test_game_over_frozen();
    int keepX;
    keepX = mX;
    for (int i = 0; i < 5; i++) begin
      board_x = 10'($urandom_range(0, 1023));
      step_tick = 1'b1; launch = 1'b1; pause = 1'b1;
      holdNxt(); nxt_ball_x = 10'($urandom_range(0, 1023));
      cycle();
    end
    compared++; if (state !== 3'd5 || lives !== 2'd0 || ball_x !== 10'(keepX)) begin mismatched++; $display("FAIL over_frozen: got state %0d lives %0d x %0d expected 5,0,%0d", state, lives, ball_x, keepX); end
  endtask

  task automatic test_win_restart();
    start = 1'b1; cycle();
    compared++; if (state !== 3'd1 || bricks !== INIT || lives !== 2'd3 || score !== 16'd0 || ball_vy !== 10'd4) begin mismatched++; $display("FAIL restart_over: got state %0d lives %0d score %0d vy %0d", state, lives, score, ball_vy); end
    launch = 1'b1; cycle();
    holdNxt(); nxt_bricks = '0;
    step_tick = 1'b1; cycle();
    compared++; if (state !== 3'd6 || bricks !== '0 || score !== 16'd1) begin mismatched++; $display("FAIL win: got state %0d score %0d expected 6,1", state, score); end
    holdNxt(); nxt_ball_x = 10'd3; step_tick = 1'b1; cycle();
    compared++; if (state !== 3'd6 || ball_x !== 10'(mX)) begin mismatched++; $display("FAIL win_frozen: got state %0d x %0d expected 6,%0d", state, ball_x, mX); end
    start = 1'b1; cycle();
    compared++; if (state !== 3'd1 || bricks !== INIT) begin mismatched++; $display("FAIL win_restart: got state %0d bricks %h expected 1,%h", state, bricks[63:0], INIT[63:0]); end
  endtask

  task automatic test_pause();
    int keepX;
    launch = 1'b1; cycle();
    keepX = mX;
    holdNxt(); nxt_ball_x = 10'(mX + 7);
    pause = 1'b1; step_tick = 1'b1; cycle();
    compared++; if (state !== 3'd3 || ball_x !== 10'(keepX)) begin mismatched++; $display("FAIL pause_wins: got state %0d x %0d expected 3,%0d", state, ball_x, keepX); end
    step_tick = 1'b1; cycle();
    compared++; if (state !== 3'd3 || ball_x !== 10'(keepX)) begin mismatched++; $display("FAIL pause_frozen: got state %0d x %0d expected 3,%0d", state, ball_x, keepX); end
    pause = 1'b1; cycle();
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL unpause: got %0d expected 2", state); end
  endtask

  task automatic test_random_play();
    logic [63:0]   expV, gotV;
    logic [1439:0] one;
    one = 1440'd1;
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 39) == 0);
      launch    = ($urandom_range(0, 5) == 0);
      pause     = ($urandom_range(0, 24) == 0);
      step_tick = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 9) == 0) board_x = 10'($urandom_range(0, 1023));
      holdNxt();
      if ($urandom_range(0, 39) == 0) nxt_bricks = '0;
      else if ($urandom_range(0, 2) == 0) nxt_bricks = mBricks ^ (one << $urandom_range(0, 1439));
      nxt_ball_x   = 10'($urandom_range(0, 1023));
      nxt_ball_y   = 10'($urandom_range(440, 560));
      nxt_ball_dir = 2'($urandom_range(0, 3));
      nxt_coll     = 1'($urandom_range(0, 1));
      if (nxt_bricks == mBricks) nxt_ball_vy = 10'($urandom_range(1, 9));
      cycle();
      expV = {3'(mState), 2'(mLives), 16'(mScore), 10'(mX), 10'(mY), 10'(mVx), 10'(mVy), 2'(mDir), 1'(mSfx)};
      gotV = {state, lives, score, ball_x, ball_y, ball_vx, ball_vy, ball_dir, sfx_pulse};
      compared++; if (gotV !== expV) begin mismatched++; $display("FAIL random_outputs cycle %0d: got %h expected %h", i, gotV, expV); end
      compared++; if (bricks !== mBricks) begin mismatched++; $display("FAIL random_bricks cycle %0d: got %h expected %h", i, bricks[63:0], mBricks[63:0]); end
    end
  endtask

  task automatic test_async_reset();
    logic [1439:0] one;
    one = 1440'd1;
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    modelReset();
    start = 1'b1; cycle();
    launch = 1'b1; cycle();
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL async_setup: got %0d expected 2", state); end
    holdNxt(); nxt_ball_x = 10'(mX + 3); nxt_bricks = mBricks ^ one;
    step_tick = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (state !== 3'd0 || bricks !== INIT || ball_x !== 10'd0 || ball_y !== 10'd455) begin mismatched++; $display("FAIL async_reset_now: got state %0d x %0d y %0d expected 0,0,455", state, ball_x, ball_y); end
    @(posedge clk); #1;
    compared++; if (state !== 3'd0 || ball_x !== 10'd0 || score !== 16'd0 || lives !== 2'd3 || ball_vy !== 10'd4) begin mismatched++; $display("FAIL async_reset_held: got state %0d x %0d score %0d lives %0d", state, ball_x, score, lives); end
    step_tick = 1'b0;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    test_reset();
    test_serve();
    test_launch_commit();
    test_speedup();
    test_vy_ceiling();
    test_miss_lost();
    test_game_over_frozen();
    test_win_restart();
    test_pause();
    test_random_play();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
